if_id_fetch_buffer: RTL and testbench

- Instruction fetch buffer and IF/ID pipeline boundary, directly downstream of the program counter stage.
- Captures {pc, instruction} pairs returned from instruction memory and queues them in a small FIFO.
- Presents the queue head to decode with a valid/ready handshake.
- Back-pressures the PC stage when full, discards wrong-path fetches on branch/jump flush, and injects NOPs when empty.

---
 rtl/if_id_fetch_buffer.sv | 93 +++++++++
 tb/tb_if_id_fetch_buffer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/if_id_fetch_buffer.sv
// IF/ID fetch buffer: queues {pc, inst} pairs from instruction memory and hands
// the head to decode with valid/ready, dropping wrong-path words on flush.
module if_id_fetch_buffer #(
  parameter int          DATA_W   = 32,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_valid,
  input  logic [DATA_W-1:0]        if_pc,
  input  logic [DATA_W-1:0]        if_inst,
  input  logic                     if_inflight,
  output logic                     if_ready,
  input  logic                     flush,
  input  logic                     id_ready,
  output logic                     id_valid,
  output logic [DATA_W-1:0]        id_pc,
  output logic [DATA_W-1:0]        id_inst,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] last_pc;
  logic              drop_next;
  logic              push;
  logic              pop;
  logic              ovf_evt;

  assign if_ready = (count < DEPTH_C);
  assign id_valid = (count != '0);
  assign push     = if_valid & if_ready & ~flush & ~drop_next;
  assign pop      = id_valid & id_ready & ~flush;
  assign ovf_evt  = if_valid & ~if_ready & ~flush & ~drop_next;

  // Storage: data only, never reset; occupancy decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= if_pc;
      inst_mem[wr_ptr] <= if_inst;
    end
  end

  // Control: pointers, occupancy, stale-beat drop and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      drop_next <= 1'b0;
      overflow  <= 1'b0;
      last_pc   <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      // A fetch still in flight will return wrong-path data; remember to eat it.
      drop_next <= drop_next | (if_inflight & ~if_valid);
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        last_pc <= pc_mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop_next && if_valid) drop_next <= 1'b0;
      if (ovf_evt) overflow <= 1'b1;
    end
  end

  // Decode side: head entry while valid, NOP otherwise; pc sticks at the last one consumed.
  always_comb begin
    id_pc   = last_pc;
    id_inst = NOP_INST;
    if (id_valid) begin
      id_pc   = pc_mem[rd_ptr];
      id_inst = inst_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_if_id_fetch_buffer.sv
// Directed, table-driven bench for if_id_fetch_buffer plus a hand-written
// back-pressure sequence.
module tb_if_id_fetch_buffer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_inflight;
  logic        if_ready;
  logic        flush;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [1:0]  count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  if_id_fetch_buffer #(.DATA_W(32), .DEPTH(2), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_inflight(if_inflight), .if_ready(if_ready), .flush(flush), .id_ready(id_ready),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] pc;
    logic        infl;
    logic        fl;
    logic        idr;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    int          ecnt;
    logic        erdy;
    logic        eovf;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  function automatic vec_t mk(input logic r, input logic iv, input logic [31:0] pc,
                              input logic infl, input logic fl, input logic idr,
                              input logic ev, input logic [31:0] epc, input int ecnt,
                              input logic erdy, input logic eovf);
    vec_t v;
    v.rst = r; v.iv = iv; v.pc = pc; v.infl = infl; v.fl = fl; v.idr = idr;
    v.ev = ev; v.epc = epc; v.einst = ev ? inst_of(epc) : NOP;
    v.ecnt = ecnt; v.erdy = erdy; v.eovf = eovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic iv, input logic [31:0] pc,
                       input logic infl, input logic fl, input logic idr);
    rst = r; if_valid = iv; if_pc = pc; if_inst = inst_of(pc);
    if_inflight = infl; flush = fl; id_ready = idr;
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    // rst iv pc infl fl idr | ev epc cnt rdy ovf
    vecs.push_back(mk(0,0,32'h00,0,0,0, 0,32'h00,0,1,0)); // reset
    vecs.push_back(mk(1,1,32'h00,0,0,1, 1,32'h00,1,1,0)); // stream
    vecs.push_back(mk(1,1,32'h04,0,0,1, 1,32'h04,1,1,0));
    vecs.push_back(mk(1,1,32'h08,0,0,1, 1,32'h08,1,1,0));
    vecs.push_back(mk(1,0,32'h00,0,0,1, 0,32'h08,0,1,0));
    vecs.push_back(mk(1,1,32'h10,0,0,0, 1,32'h10,1,1,0)); // fill
    vecs.push_back(mk(1,1,32'h14,0,0,0, 1,32'h10,2,0,0));
    vecs.push_back(mk(1,1,32'h18,0,0,0, 1,32'h10,2,0,1)); // overflow
    vecs.push_back(mk(1,0,32'h00,0,0,1, 1,32'h14,1,1,1));
    vecs.push_back(mk(1,0,32'h00,0,0,1, 0,32'h14,0,1,1));
    vecs.push_back(mk(1,1,32'h20,0,0,1, 1,32'h20,1,1,1)); // push+pop wrap
    vecs.push_back(mk(1,1,32'h24,0,0,1, 1,32'h24,1,1,1));
    vecs.push_back(mk(1,1,32'h28,0,0,1, 1,32'h28,1,1,1));
    vecs.push_back(mk(1,1,32'h2C,0,0,1, 1,32'h2C,1,1,1));
    vecs.push_back(mk(1,0,32'h00,0,0,1, 0,32'h2C,0,1,1));
    vecs.push_back(mk(1,1,32'h30,0,0,0, 1,32'h30,1,1,1)); // flush queued
    vecs.push_back(mk(1,1,32'h34,0,0,0, 1,32'h30,2,0,1));
    vecs.push_back(mk(1,1,32'h38,0,1,1, 0,32'h2C,0,1,1));
    vecs.push_back(mk(1,1,32'h50,0,0,0, 1,32'h50,1,1,1)); // flush blocks push
    vecs.push_back(mk(1,1,32'h54,0,1,0, 0,32'h2C,0,1,1));
    vecs.push_back(mk(1,0,32'h00,0,0,0, 0,32'h2C,0,1,1));
    vecs.push_back(mk(1,0,32'h00,1,1,0, 0,32'h2C,0,1,1)); // in-flight drop
    vecs.push_back(mk(1,1,32'h3C,0,0,0, 0,32'h2C,0,1,1));
    vecs.push_back(mk(1,1,32'h100,0,0,0, 1,32'h100,1,1,1));
    vecs.push_back(mk(1,0,32'h00,0,0,1, 0,32'h100,0,1,1));
    vecs.push_back(mk(1,0,32'h00,1,1,0, 0,32'h100,0,1,1)); // double flush
    vecs.push_back(mk(1,0,32'h00,1,1,0, 0,32'h100,0,1,1));
    vecs.push_back(mk(1,1,32'h60,0,0,0, 0,32'h100,0,1,1));
    vecs.push_back(mk(1,1,32'h64,0,0,0, 1,32'h64,1,1,1));
    vecs.push_back(mk(1,0,32'h00,0,0,1, 0,32'h64,0,1,1));
    vecs.push_back(mk(1,1,32'h70,0,0,0, 1,32'h70,1,1,1)); // reset mid-op
    vecs.push_back(mk(1,1,32'h74,0,0,0, 1,32'h70,2,0,1));
    vecs.push_back(mk(0,0,32'h00,0,0,0, 0,32'h00,0,1,0));
    vecs.push_back(mk(1,1,32'h80,0,0,0, 1,32'h80,1,1,0));
    vecs.push_back(mk(1,1,32'h84,0,0,0, 1,32'h80,2,0,0));
    vecs.push_back(mk(1,0,32'h00,0,0,1, 1,32'h84,1,1,0));
    vecs.push_back(mk(1,0,32'h00,0,0,1, 0,32'h84,0,1,0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].pc, vecs[i].infl, vecs[i].fl, vecs[i].idr);
      tick();
      chk($sformatf("v%0d id_valid", i), {31'b0, id_valid}, {31'b0, vecs[i].ev});
      chk($sformatf("v%0d id_pc", i), id_pc, vecs[i].epc);
      chk($sformatf("v%0d id_inst", i), id_inst, vecs[i].einst);
      chk($sformatf("v%0d count", i), {30'b0, count}, 32'(vecs[i].ecnt));
      chk($sformatf("v%0d if_ready", i), {31'b0, if_ready}, {31'b0, vecs[i].erdy});
      chk($sformatf("v%0d overflow", i), {31'b0, overflow}, {31'b0, vecs[i].eovf});
    end

    // Full buffer: raising id_ready must not raise if_ready before the edge.
    drive(1, 1, 32'h90, 0, 0, 0); tick();
    drive(1, 1, 32'h94, 0, 0, 0); tick();
    drive(1, 0, 32'h00, 0, 0, 1);
    #1;
    chk("full if_ready pre-edge", {31'b0, if_ready}, 32'd0);
    chk("full head pc", id_pc, 32'h90);
    chk("full count", {30'b0, count}, 32'd2);
    tick();
    chk("after pop if_ready", {31'b0, if_ready}, 32'd1);
    chk("after pop head pc", id_pc, 32'h94);
    chk("after pop head inst", id_inst, inst_of(32'h94));
    tick();
    chk("drained id_valid", {31'b0, id_valid}, 32'd0);
    chk("drained id_inst", id_inst, NOP);
    chk("drained id_pc", id_pc, 32'h94);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
